charaan_therm_cond: RTL and testbench

//  Comparator-side conditioning stage of the 3-bit flash ADC; sits directly upstream of the priority encoder.

---
 rtl/charaan_therm_cond.sv | 120 ++++++++++++
 tb/tb_charaan_therm_cond.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/charaan_therm_cond.sv
// rtl/charaan_therm_cond.sv - comparator-bank conditioning stage for the 3-bit flash ADC
//
// Purpose: synchronise the asynchronous comparator bank, sample it every DIV
// cycles, correct bubbles into a legal thermometer code (bit0 forced to 1) and
// present it over a valid/ready handshake with underrange/bubble/overrun flags
// and a saturating bubble-error counter.
//
// Ports:
//   clk          clock, all logic on rising edge
//   rst_n        synchronous active-low reset
//   en           sampling enable
//   comp_in      raw asynchronous comparator outputs
//   therm_out    corrected thermometer code
//   therm_valid  therm_out/flags hold a sample not yet accepted
//   therm_ready  downstream accept
//   underrange   corrected bit0 of the sample was 0
//   bubble_err   raw sample was not a legal thermometer code
//   overrun      one-cycle pulse when a sample is dropped under backpressure
//   err_count    saturating count of loaded samples with bubble_err set
//   err_clr      synchronous clear of err_count
module charaan_therm_cond #(
  parameter int DIV         = 4,
  parameter int SYNC_STAGES = 2,
  parameter int ERR_CNT_W   = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic [7:0]           comp_in,
  output logic [7:0]           therm_out,
  output logic                 therm_valid,
  input  logic                 therm_ready,
  output logic                 underrange,
  output logic                 bubble_err,
  output logic                 overrun,
  output logic [ERR_CNT_W-1:0] err_count,
  input  logic                 err_clr
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [7:0]    sync_q [SYNC_STAGES];
  logic [7:0]    s;
  logic [CW-1:0] cnt;
  logic          tick;
  logic          load;
  logic [9:0]    se;
  logic [7:0]    c;
  logic [7:0]    p;
  logic [7:0]    t;
  logic          underrange_n;
  logic          bubble_n;

  // Synchroniser runs regardless of en so s is always settled when sampling starts.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
    end else begin
      sync_q[0] <= comp_in;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  assign tick = en & (cnt == CW'(DIV - 1));

  always_ff @(posedge clk) begin
    if (!rst_n || !en) cnt <= '0;
    else if (tick)     cnt <= '0;
    else               cnt <= cnt + 1'b1;
  end

  // se pads s with the implied neighbours: below threshold 0 is always 1,
  // above threshold 7 is always 0. se[i+1] == s[i].
  always_comb begin
    logic run;
    se  = {1'b0, s, 1'b1};
    c   = '0;
    p   = '0;
    run = 1'b1;
    for (int i = 0; i < 8; i++) begin
      c[i] = (se[i] & se[i+1]) | (se[i] & se[i+2]) | (se[i+1] & se[i+2]);
      run  = run & c[i];
      p[i] = run;
    end
    t            = p | 8'h01;
    underrange_n = ~c[0];
    bubble_n     = |(s[7:1] & ~s[6:0]);
  end

  assign load = tick & (~therm_valid | therm_ready);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      therm_out   <= 8'h01;
      therm_valid <= 1'b0;
      underrange  <= 1'b0;
      bubble_err  <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      overrun <= tick & therm_valid & ~therm_ready;
      if (load) begin
        therm_out   <= t;
        underrange  <= underrange_n;
        bubble_err  <= bubble_n;
        therm_valid <= 1'b1;
      end else if (therm_valid & therm_ready) begin
        therm_valid <= 1'b0;
      end
    end
  end

  // Only samples that actually reach the output register are counted.
  always_ff @(posedge clk) begin
    if (!rst_n || err_clr)            err_count <= '0;
    else if (load & bubble_n & ~(&err_count)) err_count <= err_count + 1'b1;
  end

endmodule

// File: tb/tb_charaan_therm_cond.sv
// tb/tb_charaan_therm_cond.sv - scoreboard bench for charaan_therm_cond
module tb_charaan_therm_cond;

  logic       clk = 1'b0;
  logic       rst_n, en, therm_ready, err_clr;
  logic [7:0] comp_in;
  logic [7:0] therm_out;
  logic       therm_valid, underrange, bubble_err, overrun;
  logic [7:0] err_count;

  logic       en2, err_clr2, ready2;
  logic [7:0] therm_out2;
  logic       therm_valid2, underrange2, bubble_err2, overrun2;
  logic [1:0] err_count2;

  typedef struct {
    logic [7:0] t;
    logic       u;
    logic       b;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   err_exp = 0;

  always #5 clk = ~clk;

  charaan_therm_cond #(.DIV(4), .SYNC_STAGES(2), .ERR_CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .comp_in(comp_in),
    .therm_out(therm_out), .therm_valid(therm_valid), .therm_ready(therm_ready),
    .underrange(underrange), .bubble_err(bubble_err), .overrun(overrun),
    .err_count(err_count), .err_clr(err_clr)
  );

  charaan_therm_cond #(.DIV(1), .SYNC_STAGES(2), .ERR_CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .en(en2), .comp_in(comp_in),
    .therm_out(therm_out2), .therm_valid(therm_valid2), .therm_ready(ready2),
    .underrange(underrange2), .bubble_err(bubble_err2), .overrun(overrun2),
    .err_count(err_count2), .err_clr(err_clr2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard pop: every sample presented while ready is high is compared.
  always @(negedge clk) begin
    if (rst_n && therm_valid && therm_ready) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_therm", therm_out, e.t);
        chk("sb_under", underrange, e.u);
        chk("sb_bubble", bubble_err, e.b);
      end
    end
  end

  task automatic run(input logic [7:0] code, input logic [7:0] et, input logic eu,
                     input logic eb, input int n);
    int cyc = 0;
    int vh  = 0;
    comp_in = code;
    repeat (4) step();
    for (int i = 0; i < n; i++) sb.push_back('{et, eu, eb});
    en = 1'b1;
    while (sb.size() != 0 && cyc < 200) begin
      step();
      cyc++;
      if (therm_valid) vh++;
    end
    en = 1'b0;
    chk("drain", sb.size(), 0);
    chk("valid_cnt", vh, n);
    chk("valid_cycles", cyc, 4 * n + 1);
    if (eb) err_exp += n;
    chk("err_count", err_count, err_exp);
  endtask

  initial begin
    int ov;
    rst_n = 1'b0; en = 1'b1; therm_ready = 1'b1; err_clr = 1'b0; comp_in = 8'hFF;
    en2 = 1'b0; err_clr2 = 1'b0; ready2 = 1'b1;

    // T1 reset and first-sample latency
    repeat (3) step();
    @(negedge clk);
    chk("rst_valid", therm_valid, 0);
    chk("rst_therm", therm_out, 8'h01);
    chk("rst_err", err_count, 0);
    chk("rst_flags", {underrange, bubble_err, overrun}, 3'b000);
    sb.push_back('{8'hFF, 1'b0, 1'b0});
    rst_n = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      chk("t1_no_valid_yet", therm_valid, 0);
    end
    @(negedge clk);
    chk("t1_valid_edge4", therm_valid, 1);
    step();
    en = 1'b0;
    chk("t1_drain", sb.size(), 0);

    // T2 clean code, T3 bubbles, T4 underrange
    run(8'h1F, 8'h1F, 1'b0, 1'b0, 3);
    run(8'h17, 8'h0F, 1'b0, 1'b1, 2);
    run(8'hAA, 8'h01, 1'b0, 1'b1, 1);
    run(8'h00, 8'h01, 1'b1, 1'b0, 2);
    run(8'h07, 8'h07, 1'b0, 1'b0, 1);

    // T5 backpressure
    comp_in = 8'hFF;
    repeat (4) step();
    sb.push_back('{8'hFF, 1'b0, 1'b0});
    therm_ready = 1'b0;
    en = 1'b1;
    repeat (4) step();
    chk("t5_valid", therm_valid, 1);
    comp_in = 8'h17;
    ov = 0;
    for (int k = 0; k < 13; k++) begin
      step();
      chk("t5_stable", {therm_out, bubble_err, underrange}, {8'hFF, 2'b00});
      ov += int'(overrun);
    end
    chk("t5_overruns", ov, 3);
    chk("t5_err_hold", err_count, err_exp);
    step();
    step();
    sb.push_back('{8'h0F, 1'b0, 1'b1});
    therm_ready = 1'b1;
    step();
    chk("t5_valid_kept", therm_valid, 1);
    chk("t5_no_overrun", overrun, 0);
    err_exp++;
    chk("t5_err_inc", err_count, err_exp);
    en = 1'b0;
    step();
    chk("t5_accepted", therm_valid, 0);
    chk("t5_drain", sb.size(), 0);

    // T6 saturating counter on a 2-bit instance, DIV=1
    en2 = 1'b1;
    step();
    step();
    chk("t6_cnt2", err_count2, 2);
    repeat (3) step();
    chk("t6_sat", err_count2, 3);
    chk("t6_therm", {therm_out2, bubble_err2, underrange2, overrun2}, {8'h0F, 3'b100});
    err_clr2 = 1'b1;
    step();
    chk("t6_clr_priority", err_count2, 0);
    err_clr2 = 1'b0;
    en2 = 1'b0;
    step();

    err_clr = 1'b1;
    step();
    chk("err_clr", err_count, 0);
    err_clr = 1'b0;

    // Reset while a sample is pending discards it
    therm_ready = 1'b0;
    comp_in = 8'h3F;
    repeat (4) step();
    en = 1'b1;
    repeat (4) step();
    chk("pend_valid", therm_valid, 1);
    rst_n = 1'b0;
    step();
    chk("pend_rst_valid", therm_valid, 0);
    chk("pend_rst_therm", therm_out, 8'h01);
    rst_n = 1'b1;
    en = 1'b0;
    therm_ready = 1'b1;
    step();
    chk("post_rst_valid", therm_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
